// File: rtl/lsu_bus_master_if.sv
// Split read/write valid/ready bus between the load/store master and data memory.
// Signal suffixes are from the master's point of view.
interface lsu_bus_master_if;
  logic [31:0] araddr_o;
  logic        arvalid_o;
  logic        arready_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rvalid_i;
  logic        rready_o;
  logic [31:0] awaddr_o;
  logic        awvalid_o;
  logic        awready_i;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wvalid_o;
  logic        wready_i;
  logic [1:0]  bresp_i;
  logic        bvalid_i;
  logic        bready_o;

  modport master (
    output araddr_o, arvalid_o, rready_o, awaddr_o, awvalid_o, wdata_o, wstrb_o, wvalid_o,
           bready_o,
    input  arready_i, rdata_i, rresp_i, rvalid_i, awready_i, wready_i, bresp_i, bvalid_i
  );

  modport slave (
    input  araddr_o, arvalid_o, rready_o, awaddr_o, awvalid_o, wdata_o, wstrb_o, wvalid_o,
           bready_o,
    output arready_i, rdata_i, rresp_i, rvalid_i, awready_i, wready_i, bresp_i, bvalid_i
  );
endinterface

// File: rtl/lsu_bus_master.sv
// Load/store initiator: one request per transaction onto a split read/write bus, with
// byte-lane placement, misalignment rejection and load-data extension.
module lsu_bus_master (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_wen_i,
  input  logic [31:0]             req_addr_i,
  input  logic [31:0]             req_wdata_i,
  input  logic [1:0]              req_size_i,
  input  logic                    req_unsigned_i,
  lsu_bus_master_if.master        bus,
  output logic                    done_o,
  output logic                    err_o,
  output logic [31:0]             rdata_o
);

  typedef enum logic [2:0] {StIdle, StAr, StR, StAwW, StB} state_e;

  state_e      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic        r_aw_done;
  logic        r_w_done;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_rdata;

  logic        w_misaligned;
  logic [3:0]  w_strb_base;
  logic [31:0] w_shifted;
  logic [31:0] w_load;
  logic        w_aw_fin;
  logic        w_w_fin;

  always_comb begin
    w_misaligned = 1'b0;
    w_strb_base  = 4'b1111;
    unique case (req_size_i)
      2'd0: begin w_misaligned = 1'b0;              w_strb_base = 4'b0001; end
      2'd1: begin w_misaligned = req_addr_i[0];     w_strb_base = 4'b0011; end
      2'd2: begin w_misaligned = |req_addr_i[1:0];  w_strb_base = 4'b1111; end
      2'd3: begin w_misaligned = 1'b1;              w_strb_base = 4'b0000; end
    endcase
  end

  always_comb begin
    w_shifted = bus.rdata_i >> {r_addr[1:0], 3'b000};
    w_load    = w_shifted;
    unique case (r_size)
      2'd0:    w_load = {{24{~r_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      2'd1:    w_load = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  // A channel counts as finished if it completed earlier or is handshaking right now.
  assign w_aw_fin = r_aw_done | bus.awready_i;
  assign w_w_fin  = r_w_done  | bus.wready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (req_valid_i) begin
            r_addr     <= req_addr_i;
            r_size     <= req_size_i;
            r_unsigned <= req_unsigned_i;
            r_wdata    <= req_wdata_i << {req_addr_i[1:0], 3'b000};
            r_wstrb    <= w_strb_base << req_addr_i[1:0];
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            if (w_misaligned) begin
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_rdata <= '0;
            end else if (req_wen_i) begin
              r_state <= StAwW;
            end else begin
              r_state <= StAr;
            end
          end
        end
        StAr: begin
          if (bus.arready_i) r_state <= StR;
        end
        StR: begin
          if (bus.rvalid_i) begin
            r_state <= StIdle;
            r_done  <= 1'b1;
            r_err   <= |bus.rresp_i;
            r_rdata <= (|bus.rresp_i) ? 32'h0 : w_load;
          end
        end
        StAwW: begin
          if (bus.awready_i) r_aw_done <= 1'b1;
          if (bus.wready_i)  r_w_done  <= 1'b1;
          if (w_aw_fin && w_w_fin) r_state <= StB;
        end
        StB: begin
          if (bus.bvalid_i) begin
            r_state <= StIdle;
            r_done  <= 1'b1;
            r_err   <= |bus.bresp_i;
            r_rdata <= '0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready_o   = (r_state == StIdle);
  assign bus.arvalid_o = (r_state == StAr);
  assign bus.araddr_o  = r_addr;
  assign bus.rready_o  = (r_state == StR);
  assign bus.awvalid_o = (r_state == StAwW) && !r_aw_done;
  assign bus.awaddr_o  = r_addr;
  assign bus.wvalid_o  = (r_state == StAwW) && !r_w_done;
  assign bus.wdata_o   = r_wdata;
  assign bus.wstrb_o   = r_wstrb;
  assign bus.bready_o  = (r_state == StB);
  assign done_o        = r_done;
  assign err_o         = r_err;
  assign rdata_o       = r_rdata;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: vector table driven through a cycle-accurate responder,
// plus back-to-back, mid-transaction reset and pulse-width sequences.
module tb_lsu_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;

  lsu_bus_master_if bus_if ();

  lsu_bus_master dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_wen_i      (req_wen),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .bus            (bus_if),
    .done_o         (done),
    .err_o          (err),
    .rdata_o        (rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rdat;
    logic [1:0]  resp;
    int          aw_dly;
    int          w_dly;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic        exp_bus;
    int          exp_lat;
  } vec_t;

  vec_t vecs[15];
  vec_t v_st;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic clear_resp();
    bus_if.arready_i = 1'b0;
    bus_if.rvalid_i  = 1'b0;
    bus_if.rdata_i   = '0;
    bus_if.rresp_i   = '0;
    bus_if.awready_i = 1'b0;
    bus_if.wready_i  = 1'b0;
    bus_if.bvalid_i  = 1'b0;
    bus_if.bresp_i   = '0;
  endtask

  // Call at a negedge; returns at the negedge where done is seen (or after the cycle budget).
  task automatic run(input vec_t v, input bit hold, input string nm);
    int          done_c;
    logic        got_err;
    logic [31:0] got_rd;
    logic [31:0] got_wd;
    logic [3:0]  got_ws;
    bit          bus_seen;
    bit          aw_alone;
    bit          w_alone;
    bit          addr_ok;
    done_c = -1; got_err = 1'b0; got_rd = '0; got_wd = '0; got_ws = '0;
    bus_seen = 0; aw_alone = 0; w_alone = 0; addr_ok = 1;
    chk({nm, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_wen      = v.wen;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    req_size     = v.size;
    req_unsigned = v.uns;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) req_valid = 1'b0;
      if (bus_if.arvalid_o || bus_if.awvalid_o || bus_if.wvalid_o) bus_seen = 1;
      if (bus_if.arvalid_o && bus_if.araddr_o !== v.addr) addr_ok = 0;
      if (bus_if.awvalid_o && bus_if.awaddr_o !== v.addr) addr_ok = 0;
      if (bus_if.wvalid_o) begin
        got_wd = bus_if.wdata_o;
        got_ws = bus_if.wstrb_o;
      end
      if (!bus_if.awvalid_o && bus_if.wvalid_o) aw_alone = 1;
      if (bus_if.awvalid_o && !bus_if.wvalid_o) w_alone = 1;
      if (done) begin
        done_c  = c;
        got_err = err;
        got_rd  = rdata;
        break;
      end
      bus_if.arready_i = bus_if.arvalid_o;
      bus_if.rvalid_i  = bus_if.rready_o;
      bus_if.rdata_i   = bus_if.rready_o ? v.rdat : 32'h0;
      bus_if.rresp_i   = v.resp;
      bus_if.awready_i = bus_if.awvalid_o && (c > v.aw_dly);
      bus_if.wready_i  = bus_if.wvalid_o && (c > v.w_dly);
      bus_if.bvalid_i  = bus_if.bready_o;
      bus_if.bresp_i   = v.resp;
    end
    clear_resp();
    chk({nm, "_lat"}, 32'(done_c), 32'(v.exp_lat));
    chk({nm, "_err"}, {31'b0, got_err}, {31'b0, v.exp_err});
    chk({nm, "_bus"}, {31'b0, bus_seen}, {31'b0, v.exp_bus});
    chk({nm, "_addr"}, {31'b0, addr_ok}, 32'd1);
    if (!v.wen) chk({nm, "_rdata"}, got_rd, v.exp_rdata);
    if (v.wen && v.exp_bus) begin
      chk({nm, "_wdata"}, got_wd, v.exp_wdata);
      chk({nm, "_wstrb"}, {28'b0, got_ws}, {28'b0, v.exp_wstrb});
      chk({nm, "_aw_alone"}, {31'b0, aw_alone}, {31'b0, v.aw_dly < v.w_dly});
      chk({nm, "_w_alone"}, {31'b0, w_alone}, {31'b0, v.w_dly < v.aw_dly});
    end
  endtask

  initial begin
    int t0;
    //          wen   addr          wdata         sz    u     rdat          rsp  aw w
    //          err   exp_rdata     exp_wdata     strb     bus   lat
    vecs[0]  = '{1'b0, 32'h8000_0003, 32'h0,        2'd0, 1'b0, 32'h80FF_1234, 2'd0, 0, 0,
                 1'b0, 32'hFFFF_FF80, 32'h0,        4'b0000, 1'b1, 3};
    vecs[1]  = '{1'b0, 32'h8000_0003, 32'h0,        2'd0, 1'b1, 32'h80FF_1234, 2'd0, 0, 0,
                 1'b0, 32'h0000_0080, 32'h0,        4'b0000, 1'b1, 3};
    vecs[2]  = '{1'b0, 32'h8000_0002, 32'h0,        2'd1, 1'b0, 32'h80FF_1234, 2'd0, 0, 0,
                 1'b0, 32'hFFFF_80FF, 32'h0,        4'b0000, 1'b1, 3};
    vecs[3]  = '{1'b0, 32'h8000_0000, 32'h0,        2'd2, 1'b0, 32'h1234_5678, 2'd0, 0, 0,
                 1'b0, 32'h1234_5678, 32'h0,        4'b0000, 1'b1, 3};
    vecs[4]  = '{1'b0, 32'h8000_0001, 32'h0,        2'd0, 1'b1, 32'h80FF_1234, 2'd0, 0, 0,
                 1'b0, 32'h0000_0012, 32'h0,        4'b0000, 1'b1, 3};
    vecs[5]  = '{1'b0, 32'h8000_0000, 32'h0,        2'd1, 1'b0, 32'h1234_F00D, 2'd0, 0, 0,
                 1'b0, 32'hFFFF_F00D, 32'h0,        4'b0000, 1'b1, 3};
    vecs[6]  = '{1'b0, 32'h8000_0008, 32'h0,        2'd2, 1'b0, 32'hCAFE_F00D, 2'd2, 0, 0,
                 1'b1, 32'h0000_0000, 32'h0,        4'b0000, 1'b1, 3};
    vecs[7]  = '{1'b0, 32'h8000_0001, 32'h0,        2'd2, 1'b0, 32'hDEAD_BEEF, 2'd0, 0, 0,
                 1'b1, 32'h0000_0000, 32'h0,        4'b0000, 1'b0, 1};
    vecs[8]  = '{1'b1, 32'h8000_0003, 32'h0000_1234, 2'd1, 1'b0, 32'h0,        2'd0, 0, 0,
                 1'b1, 32'h0000_0000, 32'h0,        4'b0000, 1'b0, 1};
    vecs[9]  = '{1'b0, 32'h8000_0000, 32'h0,        2'd3, 1'b0, 32'h1111_1111, 2'd0, 0, 0,
                 1'b1, 32'h0000_0000, 32'h0,        4'b0000, 1'b0, 1};
    vecs[10] = '{1'b1, 32'h8000_0002, 32'h0000_ABCD, 2'd1, 1'b0, 32'h0,        2'd0, 0, 3,
                 1'b0, 32'h0,         32'hABCD_0000, 4'b1100, 1'b1, 6};
    vecs[11] = '{1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'h0,        2'd2, 0, 0,
                 1'b1, 32'h0,         32'hDEAD_BEEF, 4'b1111, 1'b1, 3};
    vecs[12] = '{1'b1, 32'h8000_0001, 32'h0000_00A5, 2'd0, 1'b0, 32'h0,        2'd0, 2, 2,
                 1'b0, 32'h0,         32'h0000_A500, 4'b0010, 1'b1, 5};
    vecs[13] = '{1'b1, 32'h8000_0003, 32'h0000_005A, 2'd0, 1'b0, 32'h0,        2'd0, 0, 2,
                 1'b0, 32'h0,         32'h5A00_0000, 4'b1000, 1'b1, 5};
    vecs[14] = '{1'b1, 32'h8000_0000, 32'hFFFF_1234, 2'd1, 1'b0, 32'h0,        2'd0, 1, 0,
                 1'b0, 32'h0,         32'hFFFF_1234, 4'b0011, 1'b1, 4};
    v_st     = '{1'b1, 32'h8000_0010, 32'h0102_0304, 2'd2, 1'b0, 32'h0,        2'd0, 0, 0,
                 1'b0, 32'h0,         32'h0102_0304, 4'b1111, 1'b1, 3};

    clear_resp();
    @(negedge clk);
    chk("reset_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_done_err", {30'b0, done, err}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_valids", {27'b0, bus_if.arvalid_o, bus_if.rready_o, bus_if.awvalid_o,
                         bus_if.wvalid_o, bus_if.bready_o}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) run(vecs[i], 1'b0, $sformatf("v%0d", i));

    // Load, store, load with request valid held: each accepted in its done cycle.
    t0 = cyc_cnt;
    run(vecs[3], 1'b1, "b2b_ld0");
    run(v_st, 1'b1, "b2b_st");
    run(vecs[0], 1'b0, "b2b_ld1");
    chk("b2b_cycles", 32'(cyc_cnt - t0), 32'd9);

    @(negedge clk);
    chk("done_pulse_width", {30'b0, done, err}, 32'd0);

    // Reset while the read response is being withheld.
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0000; req_size = 2'd2;
    req_unsigned = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("midr_arvalid", {31'b0, bus_if.arvalid_o}, 32'd1);
    bus_if.arready_i = 1'b1;
    @(negedge clk);
    bus_if.arready_i = 1'b0;
    chk("midr_rready", {31'b0, bus_if.rready_o}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midr_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("midr_rst_valids", {27'b0, bus_if.arvalid_o, bus_if.rready_o, bus_if.awvalid_o,
                            bus_if.wvalid_o, bus_if.bready_o}, 32'd0);
    chk("midr_rst_rdata", rdata, 32'd0);
    chk("midr_rst_addr", bus_if.araddr_o | bus_if.awaddr_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run(vecs[4], 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
